// File: rtl/micro_seq_decoder_if.sv
// micro_seq_decoder_if
// Purpose : bundles the decode-side handshake and the uop control bus of the
//           micro-sequencing decoder.
// Ports   : master = instruction source / uop consumer (drives in_valid, op,
//           funct, reg_list, ex_stall; receives ready and the uop fields)
//           slave  = the decoder itself
interface micro_seq_decoder_if #(
  parameter int NREGS = 16,
  parameter int RIW   = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
);
  logic             in_valid;
  logic [1:0]       op;
  logic [5:0]       funct;
  logic [NREGS-1:0] reg_list;
  logic             ex_stall;
  logic             ready;
  logic             uop_valid;
  logic             branch;
  logic             reg_w;
  logic             mem_w;
  logic             mem_to_reg;
  logic             alu_src;
  logic             alu_op;
  logic [1:0]       imm_src;
  logic [1:0]       reg_src;
  logic [RIW-1:0]   uop_reg;
  logic [CW-1:0]    uop_offset;
  logic             base_wb;
  logic             undef;

  modport master (
    output in_valid, op, funct, reg_list, ex_stall,
    input  ready, uop_valid, branch, reg_w, mem_w, mem_to_reg, alu_src, alu_op,
           imm_src, reg_src, uop_reg, uop_offset, base_wb, undef
  );

  modport slave (
    input  in_valid, op, funct, reg_list, ex_stall,
    output ready, uop_valid, branch, reg_w, mem_w, mem_to_reg, alu_src, alu_op,
           imm_src, reg_src, uop_reg, uop_offset, base_wb, undef
  );
endinterface

// File: rtl/micro_seq_decoder.sv
// micro_seq_decoder
// Purpose : decodes one instruction per cycle into registered datapath
//           control uops; block transfers (LDM/STM) are expanded into one uop
//           per listed register plus an optional base-writeback uop.
// Ports   : clk  - single clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - micro_seq_decoder_if.slave (instruction in, uop out)
//
// state | meaning
// IDLE  | outputs show a single-cycle uop or nothing; next instruction welcome
// SEQ   | outputs show a block-transfer uop; rem_q holds registers still to go
// WB    | outputs show the base-writeback uop closing a block transfer
module micro_seq_decoder #(
  parameter int NREGS = 16,
  parameter int RIW   = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
) (
  input  logic clk,
  input  logic rst,
  micro_seq_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEQ = 2'd1, WB = 2'd2} state_t;

  typedef struct packed {
    logic           valid;
    logic           branch;
    logic           reg_w;
    logic           mem_w;
    logic           mem_to_reg;
    logic           alu_src;
    logic           alu_op;
    logic [1:0]     imm_src;
    logic [1:0]     reg_src;
    logic [RIW-1:0] ureg;
    logic [CW-1:0]  offset;
    logic           base_wb;
    logic           undef;
  } uop_t;

  state_t           state_q, state_n;
  uop_t             uop_q, uop_n;
  logic [NREGS-1:0] rem_q, rem_n;
  logic [CW-1:0]    k_q, k_n, cnt_q, cnt_n;
  logic             l_q, l_n, w_q, w_n;
  logic             accept;
  logic             i_bit, w_bit, l_bit;
  logic [RIW-1:0]   first_idx, rem_idx;
  logic             unused_funct;

  function automatic logic [RIW-1:0] lowest(input logic [NREGS-1:0] v);
    lowest = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (v[i]) lowest = RIW'(i);
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [NREGS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NREGS; i++)
      popcnt = popcnt + CW'(v[i]);
  endfunction

  function automatic uop_t seq_uop(input logic [RIW-1:0] r, input logic [CW-1:0] k,
                                   input logic l);
    seq_uop         = '0;
    seq_uop.valid   = 1'b1;
    seq_uop.alu_src = 1'b1;
    seq_uop.imm_src = 2'b11;
    seq_uop.ureg    = r;
    seq_uop.offset  = k;
    if (l) begin
      seq_uop.mem_to_reg = 1'b1;
      seq_uop.reg_w      = 1'b1;
    end else begin
      seq_uop.mem_w   = 1'b1;
      seq_uop.reg_src = 2'b10;
    end
  endfunction

  assign i_bit        = bus.funct[5];
  assign w_bit        = bus.funct[1];
  assign l_bit        = bus.funct[0];
  assign unused_funct = ^bus.funct[4:2];
  assign first_idx    = lowest(bus.reg_list);
  assign rem_idx      = lowest(rem_q);

  // A sequence is "on its final uop" when nothing is left to issue and no
  // writeback follows, so the next instruction can be taken without a bubble.
  assign bus.ready = !bus.ex_stall &&
                     (state_q == IDLE || state_q == WB ||
                      (state_q == SEQ && rem_q == '0 && !w_q));
  assign accept    = bus.in_valid && bus.ready;

  always_comb begin
    state_n = state_q;
    uop_n   = '0;
    rem_n   = rem_q;
    k_n     = k_q;
    cnt_n   = cnt_q;
    l_n     = l_q;
    w_n     = w_q;
    if (bus.ex_stall) begin
      uop_n = uop_q;
    end else begin
      case (state_q)
        SEQ: begin
          if (rem_q != '0) begin
            uop_n = seq_uop(rem_idx, k_q, l_q);
            rem_n = rem_q & (rem_q - NREGS'(1));
            k_n   = k_q + CW'(1);
          end else if (w_q) begin
            uop_n.valid   = 1'b1;
            uop_n.reg_w   = 1'b1;
            uop_n.alu_src = 1'b1;
            uop_n.imm_src = 2'b11;
            uop_n.base_wb = 1'b1;
            uop_n.offset  = cnt_q;
            state_n       = WB;
          end else begin
            state_n = IDLE;
          end
        end
        WB:      state_n = IDLE;
        default: state_n = IDLE;
      endcase

      if (accept) begin
        state_n     = IDLE;
        uop_n       = '0;
        uop_n.valid = 1'b1;
        case (bus.op)
          2'b00: begin
            uop_n.reg_w   = 1'b1;
            uop_n.alu_op  = 1'b1;
            uop_n.alu_src = i_bit;
          end
          2'b01: begin
            uop_n.alu_src = 1'b1;
            uop_n.imm_src = 2'b01;
            if (l_bit) begin
              uop_n.reg_w      = 1'b1;
              uop_n.mem_to_reg = 1'b1;
            end else begin
              uop_n.mem_w   = 1'b1;
              uop_n.reg_src = 2'b10;
            end
          end
          2'b10: begin
            if (i_bit) begin
              uop_n.branch  = 1'b1;
              uop_n.alu_src = 1'b1;
              uop_n.imm_src = 2'b10;
              uop_n.reg_src = 2'b01;
            end else if (bus.reg_list == '0) begin
              uop_n.undef = 1'b1;
            end else begin
              // First transfer uop issues straight from decode; the rest
              // drain from rem_q one per cycle in SEQ.
              uop_n   = seq_uop(first_idx, '0, l_bit);
              rem_n   = bus.reg_list & (bus.reg_list - NREGS'(1));
              k_n     = CW'(1);
              cnt_n   = popcnt(bus.reg_list);
              l_n     = l_bit;
              w_n     = w_bit;
              state_n = SEQ;
            end
          end
          default: uop_n.undef = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      uop_q   <= '0;
      rem_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      l_q     <= 1'b0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      uop_q   <= uop_n;
      rem_q   <= rem_n;
      k_q     <= k_n;
      cnt_q   <= cnt_n;
      l_q     <= l_n;
      w_q     <= w_n;
    end
  end

  assign bus.uop_valid  = uop_q.valid;
  assign bus.branch     = uop_q.branch;
  assign bus.reg_w      = uop_q.reg_w;
  assign bus.mem_w      = uop_q.mem_w;
  assign bus.mem_to_reg = uop_q.mem_to_reg;
  assign bus.alu_src    = uop_q.alu_src;
  assign bus.alu_op     = uop_q.alu_op;
  assign bus.imm_src    = uop_q.imm_src;
  assign bus.reg_src    = uop_q.reg_src;
  assign bus.uop_reg    = uop_q.ureg;
  assign bus.uop_offset = uop_q.offset;
  assign bus.base_wb    = uop_q.base_wb;
  assign bus.undef      = uop_q.undef;
endmodule

// File: doc/micro_seq_decoder.md
MICRO_SEQ_DECODER -- requirements
Module: micro_seq_decoder

Interface
REQ-001 Parameter NREGS, default 16, SHALL set the register-list width and the architectural register count (power of 2, at least 4).
REQ-002 Parameter RIW, default $clog2(NREGS), SHALL set the register index width.
REQ-003 Parameter CW, default $clog2(NREGS+1), SHALL set the transfer-count and offset width.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Reset  in  1  SHALL be asynchronous, active-high.
REQ-006 InValid  in  1  SHALL mark a valid instruction at decode.
REQ-007 Op  in  2  SHALL be instruction bits 27:26.
REQ-008 Funct  in  6  SHALL be instruction bits 25:20: bit 5 = I, bit 1 = W, bit 0 = L/S.
REQ-009 RegList  in  NREGS  SHALL be the block-transfer register list.
REQ-010 ExStall  in  1  SHALL freeze the block when high.
REQ-011 Ready  out  1  SHALL mean an instruction is accepted this cycle when InValid is high.
REQ-012 UopValid  out  1  SHALL qualify all control outputs below.
REQ-013 Branch, RegW, MemW, MemtoReg, ALUSrc, ALUOp  out  1 each  SHALL be the datapath controls.
REQ-014 ImmSrc, RegSrc  out  2 each  SHALL be the immediate and register-source selects.
REQ-015 UopReg  out  RIW  SHALL be the transfer register index; UopOffset  out  CW  SHALL be the word offset from base; BaseWB  out  1  SHALL flag the base-writeback uop; Undef  out  1  SHALL flag an undefined instruction.

Function
REQ-016 All outputs except Ready SHALL be registered; a uop SHALL appear exactly 1 cycle after acceptance (InValid & Ready & !ExStall).
REQ-017 No output SHALL be X; every don't-care SHALL be driven 0.
REQ-018 The FSM SHALL have three states: IDLE, SEQ, WB.
REQ-019 In IDLE, an accepted single-cycle class SHALL emit one uop and remain in IDLE.
REQ-020 Op=00, I=0 SHALL emit RegW=1, ALUOp=1, ALUSrc=0, ImmSrc=00, RegSrc=00.
REQ-021 Op=00, I=1 SHALL emit RegW=1, ALUOp=1, ALUSrc=1, ImmSrc=00, RegSrc=00.
REQ-022 Op=01, L=0 (STR) SHALL emit MemW=1, ALUSrc=1, ImmSrc=01, RegSrc=10.
REQ-023 Op=01, L=1 (LDR) SHALL emit RegW=1, MemtoReg=1, ALUSrc=1, ImmSrc=01.
REQ-024 Op=10, I=1 (B) SHALL emit Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01.
REQ-025 Op=11 SHALL emit UopValid=1 and Undef=1 with every write control at 0.
REQ-026 Op=10, I=0 (LDM/STM) SHALL latch RegList, L, W and count = popcount(RegList), then enter SEQ.
REQ-027 In SEQ, one uop SHALL be emitted per non-stalled cycle for each set bit in ascending index order.
REQ-028 SEQ uops SHALL carry UopReg = bit index, UopOffset = k, where k = 0..count-1, ALUSrc=1 and ImmSrc=11.
REQ-029 SEQ uops SHALL additionally drive MemtoReg=1, RegW=1 when L=1, or MemW=1, RegSrc=10 when L=0.
REQ-030 After the last SEQ uop, the FSM SHALL enter WB if W=1, otherwise IDLE.
REQ-031 The WB uop SHALL drive RegW=1, ALUSrc=1, ImmSrc=11, BaseWB=1, UopOffset=count, and return the FSM to IDLE.
REQ-032 An empty RegList SHALL be treated as undefined: one uop with Undef=1, no SEQ.
REQ-033 Ready SHALL be !ExStall & (IDLE, or issuing the final uop of a sequence), so back-to-back instructions have no bubble.
REQ-034 While ExStall is high, state, counters and all registered outputs SHALL hold unchanged.
REQ-035 When a cycle has no acceptance and no sequence uop, UopValid and all controls SHALL be 0 on the next edge.

Reset
REQ-036 Reset SHALL force IDLE, clear the latched list and count, and drive every registered output to 0 immediately, including mid-sequence.
REQ-037 Ready SHALL be 1 while Reset is low, the FSM is in IDLE, and ExStall is low.

Verification
REQ-038 Op=00, Funct=6'b100000, InValid=1 -> next cycle UopValid=1, RegW=1, ALUOp=1, ALUSrc=1, ImmSrc=00, Ready stays 1.
REQ-039 LDM, RegList=16'h8005, W=0 -> 3 uops with UopReg 0,2,15 and UopOffset 0,1,2, RegW=MemtoReg=1; Ready=0 for 2 cycles, then 1.
REQ-040 STM, RegList=16'h0003, W=1 -> uops with (reg 0, off 0, MemW=1), (reg 1, off 1, MemW=1), then WB with BaseWB=1, UopOffset=2, RegW=1.
REQ-041 ExStall high for 3 cycles mid-sequence -> outputs frozen during the stall, and the sequence resumes at the same k with no uop lost or duplicated.
REQ-042 Reset asserted during the second SEQ uop -> all outputs 0 asynchronously; after release Ready=1 and a new ADD decodes normally.
REQ-043 Op=11, or LDM with RegList=0 -> single uop with Undef=1, RegW=MemW=0, FSM back in IDLE.
